// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester and shared-register bus of the arbiter, grouped with master/slave views.
interface shared_reg_arbiter_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic [N-1:0]     req;
  logic [N-1:0]     d_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic             busy;
  logic             reg_en;
  logic             reg_d;
  logic             reg_q;

  modport master (
    output req, d_in, reg_q,
    input  gnt, ack, err, err_count, busy, reg_en, reg_d
  );

  modport slave (
    input  req, d_in, reg_q,
    output gnt, ack, err, err_count, busy, reg_en, reg_d
  );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Serialises N requesters onto one enabled D register: write, read back, acknowledge.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  shared_reg_arbiter_if.slave bus
);

  localparam int               IDX_W   = idx_w(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic             dat_q, dat_d, pick_valid;
  logic [N-1:0]     gnt_q, gnt_d, ack_q, ack_d;
  logic             err_q, err_d, busy_q, busy_d;
  logic             reg_en_q, reg_en_d, reg_d_q, reg_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  // Outputs are computed for the state being entered and registered with it.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    ack_d    = '0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    reg_en_d = 1'b0;
    reg_d_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d         = WRITE;
          idx_d           = pick_idx;
          dat_d           = bus.d_in[pick_idx];
          gnt_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          reg_en_d        = 1'b1;
          reg_d_d         = bus.d_in[pick_idx];
        end
      end
      WRITE: begin
        state_d      = VERIFY;
        gnt_d[idx_q] = 1'b1;
        busy_d       = 1'b1;
        reg_d_d      = dat_q;
      end
      VERIFY: begin
        state_d      = DONE;
        gnt_d[idx_q] = 1'b1;
        ack_d[idx_q] = 1'b1;
        busy_d       = 1'b1;
        reg_d_d      = dat_q;
        err_d        = (bus.reg_q != dat_q);
        if (err_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      dat_q    <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      reg_en_q <= 1'b0;
      reg_d_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.err_count = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.reg_en    = reg_en_q;
  assign bus.reg_d     = reg_d_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: N=4/CNT_W=8 and N=3/CNT_W=2 instances, each on a register model.
module tb_shared_reg_arbiter;

  typedef struct {
    bit         sel;         // 0: N=4 instance, 1: N=3 instance
    bit         rst_before;
    bit         stuck;
    bit         gap;         // grant must follow the previous one by 4 cycles
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] exp_gnt;
    logic       exp_bit;
    logic       exp_err;
    logic [7:0] exp_cnt;
    logic       exp_q;
  } vec_t;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    logic [7:0] cnt;
    logic       q;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic q_a = 1'b0;
  logic q_b = 1'b0;
  bit   stuck_a = 1'b0;
  bit   stuck_b = 1'b0;
  bit   mon_en  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_gnt = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t e_a, e_b;
  vec_t vecs[18];

  shared_reg_arbiter_if #(.N(4), .CNT_W(8)) bus_a ();
  shared_reg_arbiter_if #(.N(3), .CNT_W(2)) bus_b ();

  shared_reg_arbiter #(.N(4), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  shared_reg_arbiter #(.N(3), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Enabled D registers; "stuck" forces the cell to read back 0.
  always @(posedge clk) begin
    q_a <= stuck_a ? 1'b0 : (bus_a.reg_en ? bus_a.reg_d : q_a);
    q_b <= stuck_b ? 1'b0 : (bus_b.reg_en ? bus_b.reg_d : q_b);
  end
  assign bus_a.reg_q = q_a;
  assign bus_b.reg_q = q_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gnt_of(input bit s);
    return s ? {1'b0, bus_b.gnt} : bus_a.gnt;
  endfunction
  function automatic logic [3:0] ack_of(input bit s);
    return s ? {1'b0, bus_b.ack} : bus_a.ack;
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic reg_en_of(input bit s);
    return s ? bus_b.reg_en : bus_a.reg_en;
  endfunction
  function automatic logic reg_d_of(input bit s);
    return s ? bus_b.reg_d : bus_a.reg_d;
  endfunction

  function automatic vec_t mk(input bit s, input bit rb, input bit st, input bit gp,
                              input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                              input logic b, input logic e, input logic [7:0] c, input logic q);
    vec_t v;
    v.sel = s; v.rst_before = rb; v.stuck = st; v.gap = gp;
    v.req = r; v.d = d; v.exp_gnt = g; v.exp_bit = b; v.exp_err = e;
    v.exp_cnt = c; v.exp_q = q;
    return v;
  endfunction

  // Scoreboard side: every ack pops the expectation pushed when the write was granted.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("gnt_a_onehot0", 32'($onehot0(bus_a.gnt)), 1);
      check("gnt_b_onehot0", 32'($onehot0(bus_b.gnt)), 1);
      if (bus_a.ack != '0) begin
        if (sb_a.size() == 0) check("ack_a_unexpected", bus_a.ack, 0);
        else begin
          e_a = sb_a.pop_front();
          check("ack_a", bus_a.ack, e_a.ack);
          check("err_a", bus_a.err, e_a.err);
          check("err_count_a", bus_a.err_count, e_a.cnt);
          check("reg_q_a", bus_a.reg_q, e_a.q);
        end
      end else check("err_a_without_ack", bus_a.err, 0);
      if (bus_b.ack != '0) begin
        if (sb_b.size() == 0) check("ack_b_unexpected", bus_b.ack, 0);
        else begin
          e_b = sb_b.pop_front();
          check("ack_b", bus_b.ack, e_b.ack[2:0]);
          check("err_b", bus_b.err, e_b.err);
          check("err_count_b", bus_b.err_count, e_b.cnt);
          check("reg_q_b", bus_b.reg_q, e_b.q);
        end
      end else check("err_b_without_ack", bus_b.err, 0);
    end
  end

  task automatic drive(input bit s, input logic [3:0] r, input logic [3:0] d, input bit st);
    if (s) begin
      bus_b.req = r[2:0]; bus_b.d_in = d[2:0]; stuck_b = st; bus_a.req = '0;
    end else begin
      bus_a.req = r; bus_a.d_in = d; stuck_a = st; bus_b.req = '0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt_a", bus_a.gnt, 0);
    check("rst_ack_a", bus_a.ack, 0);
    check("rst_busy_a", bus_a.busy, 0);
    check("rst_reg_en_a", bus_a.reg_en, 0);
    check("rst_reg_d_a", bus_a.reg_d, 0);
    check("rst_err_a", bus_a.err, 0);
    check("rst_err_count_a", bus_a.err_count, 0);
    check("rst_busy_b", bus_b.busy, 0);
    check("rst_err_count_b", bus_b.err_count, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input bit s);
    int n = 0;
    while (busy_of(s) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("returns_idle", busy_of(s), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the next IDLE cycle.
  task automatic apply_vec(input vec_t v);
    int n = 0;
    exp_t x;
    if (v.rst_before) pulse_reset();
    drive(v.sel, v.req, v.d, v.stuck);
    do begin
      @(negedge clk);
      n++;
    end while (gnt_of(v.sel) == '0 && n < 8);
    check("gnt", gnt_of(v.sel), v.exp_gnt);
    if (v.gap) check("gnt_spacing", cyc - last_gnt, 4);
    last_gnt = cyc;
    check("reg_en_write", reg_en_of(v.sel), 1);
    check("reg_d_write", reg_d_of(v.sel), v.exp_bit);
    x.ack = v.exp_gnt; x.err = v.exp_err; x.cnt = v.exp_cnt; x.q = v.exp_q;
    if (v.sel) sb_b.push_back(x); else sb_a.push_back(x);
    @(negedge clk);
    check("reg_en_verify", reg_en_of(v.sel), 0);
    check("reg_d_verify", reg_d_of(v.sel), v.exp_bit);
    @(negedge clk);
    check("ack_latency", ack_of(v.sel), v.exp_gnt);
    wait_idle(v.sel);
  endtask

  initial begin
    exp_t x;
    bus_a.req = '0; bus_a.d_in = '0;
    bus_b.req = '0; bus_b.d_in = '0;

    // N=4: single write, fairness with req held, wrap priority, readback mismatch.
    vecs[0]  = mk(0, 1, 0, 0, 4'b0001, 4'b0001, 4'b0001, 1, 0, 0, 1);
    vecs[1]  = mk(0, 1, 0, 0, 4'b1111, 4'b1010, 4'b0001, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 4'b1111, 4'b1010, 4'b0010, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 1, 4'b1111, 4'b1010, 4'b0100, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 4'b1111, 4'b1010, 4'b1000, 1, 0, 0, 1);
    vecs[5]  = mk(0, 0, 0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 4'b0100, 4'b0100, 4'b0100, 1, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0, 4'b1001, 4'b1000, 4'b1000, 1, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0, 1, 4'b1001, 4'b1000, 4'b0001, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 0);
    // N=3: pointer wrap 2 -> 0, then saturating mismatch counter at CNT_W=2.
    vecs[10] = mk(1, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 4'b0111, 4'b0100, 4'b0100, 1, 0, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 4'b0011, 4'b0001, 4'b0001, 1, 0, 0, 1);
    vecs[13] = mk(1, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0);
    vecs[14] = mk(1, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 2, 0);
    vecs[15] = mk(1, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 3, 0);
    vecs[16] = mk(1, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 3, 0);
    vecs[17] = mk(1, 0, 1, 0, 4'b0001, 4'b0001, 4'b0001, 1, 1, 3, 0);

    @(negedge clk);
    pulse_reset();
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Withdrawal: ptr=3, requester 1 drops req and d_in right after being sampled.
    drive(0, 4'b0010, 4'b0010, 0);
    @(negedge clk);
    check("wd_gnt", bus_a.gnt, 4'b0010);
    check("wd_reg_d", bus_a.reg_d, 1);
    x.ack = 4'b0010; x.err = 1'b0; x.cnt = 8'd1; x.q = 1'b1;
    sb_a.push_back(x);
    bus_a.req = '0;
    bus_a.d_in = '0;
    @(negedge clk);
    check("wd_reg_d_latched", bus_a.reg_d, 1);
    wait_idle(0);
    repeat (3) begin
      @(negedge clk);
      check("wd_no_regrant", bus_a.gnt, 0);
    end

    // Reset asserted asynchronously while in VERIFY (ptr=2, requester 3 owns the bus).
    drive(0, 4'b1000, 4'b1000, 0);
    @(negedge clk);
    check("mid_gnt_write", bus_a.gnt, 4'b1000);
    @(negedge clk);
    check("mid_gnt_verify", bus_a.gnt, 4'b1000);
    check("mid_reg_en_verify", bus_a.reg_en, 0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", bus_a.gnt, 0);
    check("mid_rst_busy", bus_a.busy, 0);
    check("mid_rst_reg_en", bus_a.reg_en, 0);
    check("mid_rst_ack", bus_a.ack, 0);
    check("mid_rst_err_count", bus_a.err_count, 0);
    bus_a.req = '0;
    @(negedge clk);
    rst = 1'b0;
    apply_vec(mk(0, 0, 0, 0, 4'b1010, 4'b0010, 4'b0010, 1, 0, 0, 1));
    apply_vec(mk(0, 0, 0, 1, 4'b1010, 4'b0010, 4'b1000, 0, 0, 0, 0));

    for (int i = 10; i < 18; i++) apply_vec(vecs[i]);

    drive(0, 4'b0000, 4'b0000, 0);
    bus_b.req = '0;
    repeat (4) @(negedge clk);
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
